// File: rtl/core_sched_pkg.sv
// rtl/core_sched_pkg.sv - state encoding and instruction decode constants for core_scheduler
package core_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    EXEC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  // Opcode-class bit positions in a 16-bit core instruction
  localparam int OP_WB_HI   = 15;
  localparam int OP_LOAD    = 14;
  localparam int OP_WB_ITEM = 13;
  localparam int OP_SPARE   = 12;
  localparam int OP_STORE   = 11;
  localparam int OP_LAST    = 10;

  // LAST is the only instruction whose opcode field [15:10] carries just the LAST bit
  localparam logic [15:0] LAST_MASK  = (16'(1) << OP_WB_HI)   | (16'(1) << OP_LOAD)  |
                                       (16'(1) << OP_WB_ITEM) | (16'(1) << OP_SPARE) |
                                       (16'(1) << OP_STORE)   | (16'(1) << OP_LAST);
  localparam logic [15:0] LAST_MATCH = 16'(1) << OP_LAST;

  function automatic logic is_last(input logic [15:0] word);
    return (word & LAST_MASK) == LAST_MATCH;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// rtl/sched_fifo.sv - synchronous instruction FIFO with flush
module sched_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Read/write pointers; flush discards every stored word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - sequences one HPU core through fill, issue and drain
// Optional perf_issue/perf_bubble counters when CORE_SCHED_PERF_EN is defined.
module core_scheduler
  import core_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  cfg_item_num,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        run,
  output logic        gen,
  output logic        update_item,
  output logic [9:0]  item_a,
  output logic        get_v,
  output logic [15:0] get_d,
  output logic        exec,
  input  logic        core_store,
  input  logic        core_last,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] store_cnt
`ifdef CORE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_bubble
`endif
);

  localparam int DW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);

  sched_state_e  state_q;
  logic [9:0]    cfg_q;
  logic [9:0]    fill_q;
  logic [DW-1:0] drain_q;
  logic          timeout_q;
  logic          last_seen_q;
  logic          exec_q;
  logic [15:0]   store_cnt_q;

  logic          start_ok;
  logic          in_stream;
  logic          push;
  logic          issue;
  logic          flush;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_rdata;

  assign start_ok  = start & ~abort & (state_q == IDLE);
  assign in_stream = (state_q == GEN) || (state_q == EXEC);
  assign s_ready   = ~fifo_full & ~last_seen_q & in_stream;
  assign push      = s_valid & s_ready;
  assign issue     = (state_q == EXEC) & ~fifo_empty;
  assign flush     = abort | start_ok;

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (s_data),
    .pop   (issue),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Run sequencing: fill phase, instruction issue, drain wait and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      fill_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      fill_q  <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_q     <= cfg_item_num;
            fill_q    <= '0;
            drain_q   <= '0;
            timeout_q <= 1'b0;
            state_q   <= (cfg_item_num != 10'd0) ? GEN : EXEC;
          end
        end
        GEN: begin
          if (fill_q == cfg_q - 10'd1) begin
            fill_q  <= '0;
            state_q <= EXEC;
          end else begin
            fill_q <= fill_q + 10'd1;
          end
        end
        EXEC: begin
          if (issue && is_last(fifo_rdata)) begin
            drain_q <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (core_last) begin
            drain_q <= '0;
            state_q <= DONE;
          end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
            drain_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Once LAST is buffered the host stream is closed until the next run
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         last_seen_q <= 1'b0;
    else if (start_ok)               last_seen_q <= 1'b0;
    else if (push && is_last(s_data)) last_seen_q <= 1'b1;
  end

  // Core latches the instruction on get_v, so execution follows one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        exec_q <= 1'b0;
    else if (abort) exec_q <= 1'b0;
    else            exec_q <= issue;
  end

  // Result counter; held across abort so the host can read partial progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   store_cnt_q <= '0;
    else if (abort)                            store_cnt_q <= store_cnt_q;
    else if (start_ok)                         store_cnt_q <= '0;
    else if (core_store && (state_q != IDLE))  store_cnt_q <= store_cnt_q + 16'd1;
  end

  assign run         = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign gen         = (state_q == GEN);
  assign update_item = (state_q == GEN);
  assign item_a      = fill_q;
  assign get_v       = issue;
  assign get_d       = issue ? fifo_rdata : 16'd0;
  assign exec        = exec_q;
  assign done        = (state_q == DONE);
  assign timeout     = timeout_q;
  assign store_cnt   = store_cnt_q;

`ifdef CORE_SCHED_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_bubble_q;

  // Saturating issue and bubble counters for throughput tuning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q  <= '0;
      perf_bubble_q <= '0;
    end else if (start_ok) begin
      perf_issue_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (issue && !(&perf_issue_q))
        perf_issue_q <= perf_issue_q + 32'd1;
      if ((state_q == EXEC) && fifo_empty && !(&perf_bubble_q))
        perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_issue  = perf_issue_q;
  assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - randomized self-checking bench for core_scheduler
module tb_core_scheduler;

  localparam int FIFO_DEPTH = 16;
  localparam int DRAIN_MAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  cfg_item_num;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        run;
  logic        gen;
  logic        update_item;
  logic [9:0]  item_a;
  logic        get_v;
  logic [15:0] get_d;
  logic        exec;
  logic        core_store;
  logic        core_last;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] store_cnt;
`ifdef CORE_SCHED_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_bubble;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] fixed_words[$];

  always #5 clk = ~clk;

  core_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DRAIN_MAX  (DRAIN_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_item_num (cfg_item_num),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .run          (run),
    .gen          (gen),
    .update_item  (update_item),
    .item_a       (item_a),
    .get_v        (get_v),
    .get_d        (get_d),
    .exec         (exec),
    .core_store   (core_store),
    .core_last    (core_last),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .store_cnt    (store_cnt)
`ifdef CORE_SCHED_PERF_EN
    ,
    .perf_issue   (perf_issue),
    .perf_bubble  (perf_bubble)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_last_w(input logic [15:0] w);
    return (w & 16'hFC00) == 16'h0400;
  endfunction

  // One complete run: start, fill, stream words ending in LAST, drain, completion.
  // dly = cycles after LAST issue at which core_last is raised (-1 = never).
  task automatic do_run(input int n_items, input int n_words, input int gmin, input int gmax,
                        input int dly, input bit extra_start);
    logic [15:0] words[$];
    logic [15:0] acc[$];
    logic [15:0] iss[$];
    logic [15:0] w;
    int gap, widx, cyc, gen_cnt, done_cnt, done_cyc, last_cyc, first_iss, last_iss;
    int occ, max_occ, exp_store, exp_done_cyc;
    int e_exec, e_gen, e_ready, e_run, e_bub, e_order;
    bit prev_getv, last_acc, last_seen, exp_ready, finished, exp_to;

    widx = 0; cyc = 0; gen_cnt = 0; done_cnt = 0; done_cyc = -1; last_cyc = -100;
    first_iss = -1; last_iss = -1; max_occ = 0; exp_store = 0;
    e_exec = 0; e_gen = 0; e_ready = 0; e_run = 0; e_bub = 0; e_order = 0;
    prev_getv = 0; last_acc = 0; last_seen = 0; finished = 0;

    if (fixed_words.size() > 0) begin
      words = fixed_words;
      fixed_words.delete();
    end else begin
      for (int i = 0; i < n_words - 1; i++) begin
        w = 16'($urandom);
        while (is_last_w(w)) w = 16'($urandom);
        words.push_back(w);
      end
      words.push_back(16'h0400 | 16'($urandom_range(1023, 0)));
    end

    cfg_item_num = 10'(n_items);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gap = int'($urandom_range(gmax, gmin));

    while (!finished && cyc < 400) begin
      if (widx < words.size()) begin
        if (gap > 0) begin
          s_valid = 1'b0;
          gap--;
        end else begin
          s_valid = 1'b1;
          s_data  = words[widx];
        end
      end else begin
        s_valid = ($urandom_range(1, 0) == 1);
        s_data  = 16'($urandom);
      end
      core_store = ($urandom_range(2, 0) == 0);
      core_last  = last_seen && (cyc == last_cyc + dly);
      start      = extra_start && busy && !done && ($urandom_range(5, 0) == 0);
      if (start) cfg_item_num = 10'($urandom_range(30, 1));
      #1;
      if (cyc == 0) begin
        check("run_started", busy, 1);
        check("timeout_cleared_on_start", timeout, 0);
        check("store_cnt_cleared_on_start", store_cnt, 0);
      end
      if (!busy && cyc > 0) finished = 1;
      occ = acc.size() - iss.size();
      if (occ > max_occ) max_occ = occ;
      exp_ready = busy && !last_seen && !last_acc && (occ < FIFO_DEPTH);
      if (s_ready !== exp_ready) e_ready++;
      if (run !== busy) e_run++;
      if (update_item !== gen) e_gen++;
      if (gen) begin
        if (item_a !== 10'(gen_cnt)) e_gen++;
        if (get_v) e_gen++;
        gen_cnt++;
      end
      if (exec !== prev_getv) e_exec++;
      prev_getv = get_v;
      if (get_v) begin
        iss.push_back(get_d);
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        if (is_last_w(get_d)) begin
          last_seen = 1;
          last_cyc  = cyc;
        end
      end else if (get_d !== 16'd0) begin
        e_bub++;
      end
      if (s_valid && s_ready) begin
        acc.push_back(s_data);
        if (is_last_w(s_data)) last_acc = 1;
        if (widx < words.size()) begin
          widx++;
          gap = int'($urandom_range(gmax, gmin));
        end
      end
      if (core_store && busy) exp_store++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    s_valid = 1'b0; core_store = 1'b0; core_last = 1'b0; start = 1'b0;

    exp_to       = !(dly >= 1 && dly <= DRAIN_MAX);
    exp_done_cyc = exp_to ? last_cyc + DRAIN_MAX + 1 : last_cyc + dly + 1;

    check("run_budget", finished, 1);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, exp_done_cyc);
    check("run_low_after_done", cyc, done_cyc + 1);
    check("timeout", timeout, exp_to);
    check("store_cnt", store_cnt, exp_store & 32'hFFFF);
    check("gen_cycles", gen_cnt, n_items);
    check("accepted_words", acc.size(), words.size());
    check("issued_words", iss.size(), words.size());
    for (int i = 0; i < words.size(); i++) begin
      if (i < acc.size() && acc[i] !== words[i]) e_order++;
      if (i < iss.size() && iss[i] !== words[i]) e_order++;
    end
    check("word_order", e_order, 0);
    check("exec_lag_errors", e_exec, 0);
    check("gen_addr_errors", e_gen, 0);
    check("s_ready_errors", e_ready, 0);
    check("run_busy_errors", e_run, 0);
    check("bubble_data_errors", e_bub, 0);
    if (gmax == 0 && n_items >= words.size()) begin
      check("first_issue_cycle", first_iss, n_items);
      check("back_to_back_issue", last_iss - first_iss, words.size() - 1);
    end
    if (gmax == 0 && n_items > FIFO_DEPTH && words.size() > FIFO_DEPTH)
      check("fifo_full_reached", max_occ, FIFO_DEPTH);

    repeat (3) @(negedge clk);
    #1;
    check("timeout_sticky", timeout, exp_to);
    check("idle_quiet", {run, gen, get_v, exec, done, s_ready}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dlys[6];
    int k;
    bit hit;
    dlys = '{1, 2, 3, 4, 5, -1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_item_num = '0;
    s_valid = 1'b0; s_data = '0; core_store = 1'b0; core_last = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_flags", {run, gen, update_item, get_v, exec, busy, done, timeout, s_ready}, 0);
    check("reset_buses", {item_a, get_d}, 0);
    check("reset_store_cnt", store_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reference example: 3 items, 3 words, core_last two cycles after LAST
    fixed_words = '{16'h8400, 16'h0800, 16'h0400};
    do_run(3, 3, 0, 0, 2, 0);

    // No fill, host gaps of two cycles
    do_run(0, 6, 2, 2, 3, 0);

    // Long fill lets the FIFO reach full; words after LAST are offered
    do_run(20, 20, 0, 0, 1, 0);

    // core_last never arrives: timeout, sticky until next start
    do_run(2, 4, 0, 1, -1, 0);
    do_run(1, 2, 0, 0, 4, 0);

    for (int r = 0; r < 8; r++)
      do_run(int'($urandom_range(20, 0)), int'($urandom_range(24, 1)), 0,
             int'($urandom_range(3, 0)), dlys[$urandom_range(5, 0)], 1);

    // Abort in the middle of the fill phase
    cfg_item_num = 10'd10; start = 1'b1; s_valid = 1'b1; s_data = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    k = 0; hit = 0;
    while (k < 20 && !hit) begin
      core_store = (k < 2);
      s_data = 16'h0100 + 16'(k);
      #1;
      if (gen && item_a == 10'd5) hit = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("abort_reached_item5", hit, 1);
    abort = 1'b1; start = 1'b1; core_store = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; core_store = 1'b0; s_valid = 1'b0;
    #1;
    check("abort_idle", {busy, run, gen, update_item, get_v, exec, done, s_ready}, 0);
    check("abort_addr_data", {item_a, get_d}, 0);
    check("abort_store_held", store_cnt, 2);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_item_num = 10'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("start_abort_same_cycle", busy, 0);
    do_run(0, 5, 0, 1, 2, 0);

    // Asynchronous reset in the middle of instruction issue
    cfg_item_num = 10'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 16'h0123; core_store = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_reset_flags", {busy, run, get_v, exec, done, timeout, s_ready}, 0);
    check("async_reset_store_cnt", store_cnt, 0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0; core_store = 1'b0;
    @(negedge clk);
    do_run(2, 5, 0, 2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
